// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
// Drives a request/ack data-memory bus from the EX/MEM register and
// stalls the pipeline until the access completes. Misaligned-access
// trapping is compiled in when MEM_MISALIGN_TRAP_EN is defined;
// otherwise low address bits are forced to the natural alignment.
module mem_access_unit #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_MEM,
  input  logic [31:0] wdata_MEM,
  input  logic        MemRW_MEM,
  input  logic        Mem2Reg_MEM,
  input  logic [2:0]  MemRdCtrl_MEM,
  input  logic [1:0]  MemWrCtrl_MEM,
  output logic        stall,
  output logic [31:0] rdata_MEM,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        bus_err,
  output logic        misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TO_VAL = 8'(ACK_TIMEOUT);

  state_t      state, state_next;
  logic [7:0]  cnt;
  logic [1:0]  ld_off;
  logic [2:0]  ld_ctrl;
  logic        ld_q;

  logic        is_store, is_access;
  logic        sz_byte, sz_half;
  logic [1:0]  eff_off;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic        trap_hit;
  logic        start, trap, ack_ok, tmo;

  // Align the raw load word to the addressed lane and extend it.
  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [1:0]  off,
                                              input logic [2:0]  ctrl);
    logic [31:0] sh;
    sh = raw >> {off, 3'b000};
    case (ctrl)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {24'd0, sh[7:0]};
      3'b101:  load_extend = {16'd0, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  assign is_store  = MemRW_MEM;
  assign is_access = MemRW_MEM | Mem2Reg_MEM;

  // Decode access size, lane offset, byte enables and replicated store data.
  always_comb begin
    sz_byte = 1'b0;
    sz_half = 1'b0;
    if (is_store) begin
      sz_byte = (MemWrCtrl_MEM == 2'b00);
      sz_half = (MemWrCtrl_MEM == 2'b01);
    end else begin
      sz_byte = (MemRdCtrl_MEM == 3'b000) || (MemRdCtrl_MEM == 3'b100);
      sz_half = (MemRdCtrl_MEM == 3'b001) || (MemRdCtrl_MEM == 3'b101);
    end
    if (sz_byte)      eff_off = addr_MEM[1:0];
    else if (sz_half) eff_off = {addr_MEM[1], 1'b0};
    else              eff_off = 2'b00;
    be_next    = 4'b1111;
    wdata_next = wdata_MEM;
    if (is_store && sz_byte) begin
      be_next    = 4'b0001 << eff_off;
      wdata_next = {4{wdata_MEM[7:0]}};
    end else if (is_store && sz_half) begin
      be_next    = 4'b0011 << eff_off;
      wdata_next = {2{wdata_MEM[15:0]}};
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_hit = is_access &&
                    ((sz_half && addr_MEM[0]) ||
                     (!sz_byte && !sz_half && (addr_MEM[1:0] != 2'b00)));
`else
  assign trap_hit = 1'b0;
`endif

  // Next-state and stall decode; stall is suppressed while reset is held.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    start      = 1'b0;
    trap       = 1'b0;
    ack_ok     = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: begin
        if (is_access) begin
          stall = 1'b1;
          if (trap_hit) begin
            trap       = 1'b1;
            state_next = DONE;
          end else begin
            start      = 1'b1;
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dm_ack) begin
          ack_ok     = 1'b1;
          state_next = DONE;
        end else if (cnt + 8'd1 == TO_VAL) begin
          tmo        = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Bus request fields and load context, latched when the access starts.
  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'd0;
      dm_wdata <= 32'd0;
      dm_be    <= 4'd0;
      ld_off   <= 2'd0;
      ld_ctrl  <= 3'd0;
      ld_q     <= 1'b0;
    end else if (start) begin
      dm_req   <= 1'b1;
      dm_we    <= is_store;
      dm_addr  <= {addr_MEM[31:2], 2'b00};
      dm_wdata <= wdata_next;
      dm_be    <= be_next;
      ld_off   <= eff_off;
      ld_ctrl  <= MemRdCtrl_MEM;
      ld_q     <= ~is_store;
    end else if (ack_ok || tmo) begin
      dm_req   <= 1'b0;
    end
  end

  // Ack-wait counter: cleared on BUSY entry, counts unacknowledged cycles.
  always_ff @(posedge clk) begin
    if (rst || start)                    cnt <= 8'd0;
    else if (state == BUSY && !ack_ok)   cnt <= cnt + 8'd1;
  end

  // Load result register: captured on ack, zeroed on a load timeout.
  always_ff @(posedge clk) begin
    if (rst)                 rdata_MEM <= 32'd0;
    else if (ack_ok && ld_q) rdata_MEM <= load_extend(dm_rdata, ld_off, ld_ctrl);
    else if (tmo && ld_q)    rdata_MEM <= 32'd0;
  end

  // Bus-error pulse, one cycle in DONE after a timeout.
  always_ff @(posedge clk) begin
    if (rst) bus_err <= 1'b0;
    else     bus_err <= tmo;
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // Misalign pulse, one cycle in DONE after a trapped access.
  always_ff @(posedge clk) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= trap;
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, giving the maximum cycles to wait for dm_ack (1..255).
REQ-002 SHALL have port clk, input, 1: rising-edge clock.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have ports addr_MEM (input, 32) and wdata_MEM (input, 32): effective address and store data from the EX/MEM register.
REQ-005 SHALL have ports MemRW_MEM (input, 1) and Mem2Reg_MEM (input, 1): store request and load request (both 1 is treated as store).
REQ-006 SHALL have port MemRdCtrl_MEM, input, 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; other codes act as LW.
REQ-007 SHALL have port MemWrCtrl_MEM, input, 2: 00 SB, 01 SH, 10/11 SW.
REQ-008 SHALL have port stall, output, 1: holds the EX/MEM register and the upstream stages.
REQ-009 SHALL have port rdata_MEM, output, 32: extended load result.
REQ-010 SHALL have ports dm_req, dm_we (output, 1), dm_addr, dm_wdata (output, 32) and dm_be (output, 4): data-memory request bus.
REQ-011 SHALL have ports dm_ack (input, 1) and dm_rdata (input, 32): memory completion and read data.
REQ-012 SHALL have ports bus_err and misalign, output, 1 each: one-cycle error pulses.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-014 IDLE transitions:
- Access = MemRW_MEM or Mem2Reg_MEM.
- With an access present: stall=1 combinationally, register the bus fields, set dm_req=1, go to BUSY.
- With no access: stall=0 and stay in IDLE.
REQ-015 BUSY behaviour:
- dm_req, dm_we, dm_addr, dm_wdata and dm_be SHALL hold stable and stall=1.
- On dm_ack=1: capture the load result (loads only), drop dm_req, go to DONE.
REQ-016 DONE SHALL assert stall=0 for exactly one cycle and then return to IDLE, so the minimum occupancy of a memory instruction is 3 cycles.
REQ-017 dm_addr SHALL be {addr_MEM[31:2],2'b00}, and dm_we SHALL be 1 for stores only.
REQ-018 Store lane and byte-enable mapping:
- SB: dm_wdata={4{wdata[7:0]}}, dm_be=4'b0001<<addr[1:0].
- SH: dm_wdata={2{wdata[15:0]}}, dm_be=4'b0011<<{addr[1],1'b0}.
- SW: dm_wdata=wdata, dm_be=4'b1111.
- Loads: dm_be=4'b1111.
REQ-019 Load result:
- Shift dm_rdata right by addr[1:0]*8.
- Sign-extend for LB/LH and zero-extend for LBU/LHU.
- Register the result into rdata_MEM on the ack cycle.
- rdata_MEM SHALL hold until the next load capture.
REQ-020 An 8-bit counter SHALL clear on entry to BUSY and increment each BUSY cycle without dm_ack.
REQ-021 When the counter reaches ACK_TIMEOUT without ack:
- Drop dm_req.
- Set rdata_MEM=0 for loads.
- Pulse bus_err for 1 cycle.
- Go to DONE.
REQ-022 dm_ack SHALL be ignored in IDLE and DONE.
REQ-023 dm_ack arriving in the same cycle as the timeout SHALL be treated as success, with no bus_err.

Reset
REQ-024 rst SHALL force IDLE within one cycle from any state, including mid-BUSY, and dm_req SHALL be 0 after that edge.
REQ-025 While rst=1 or after reset, all outputs SHALL be 0: stall, dm_req, dm_we, dm_addr, dm_wdata, dm_be, rdata_MEM, bus_err, misalign, and the counter.

Configuration
REQ-026 Macro MEM_MISALIGN_TRAP_EN controls misaligned-access handling.
- Defined: a misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0) SHALL issue no bus request, SHALL pulse misalign for 1 cycle, SHALL leave rdata_MEM unchanged, and SHALL go IDLE->DONE.
- Undefined: misalign SHALL be tied 0; halfword accesses SHALL use addr[0] forced to 0 and word accesses SHALL use addr[1:0] forced to 0.

Verification
REQ-027 The bench SHALL run an LW with addr=0x100 and dm_rdata=0xDEADBEEF, ack on the first BUSY cycle; it SHALL check stall=1,1,0 over 3 cycles, dm_addr=0x100 and rdata_MEM=0xDEADBEEF.
REQ-028 The bench SHALL run an SB with addr=0x103 and wdata=0x000000A5; it SHALL check dm_be=4'b1000, dm_wdata=0xA5A5A5A5 and dm_we=1.
REQ-029 The bench SHALL run an LB and an LBU at addr=0x102 with dm_rdata=0x12F03456; it SHALL check rdata_MEM=0xFFFFFFF0 and 0x000000F0 respectively.
REQ-030 The bench SHALL run ACK_TIMEOUT=4 with dm_ack never asserted; it SHALL check dm_req high for 4 cycles, then a bus_err pulse and stall=0 in DONE.
REQ-031 The bench SHALL assert rst during BUSY; it SHALL check dm_req=0 and stall=0 after the edge and that a late dm_ack has no effect.
REQ-032 With MEM_MISALIGN_TRAP_EN defined, the bench SHALL run an LW at addr=0x101; it SHALL check misalign pulses, dm_req stays 0 and stall=1 for 1 cycle.
